// File: rtl/nbcac_pkg.sv
// Shared constants and elaboration-time helpers for the sequential NBCAC decoder.
// Weights follow the Fibonacci-like recurrence anchored at the top wires.
package nbcac_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Weight of wire k (1-based); positions outside 1..cw_w weigh nothing.
  function automatic longint unsigned nbcac_weight(input int cw_w, input int k);
    longint unsigned w_k1, w_k2, w_k;
    if (k < 1 || k > cw_w) return 0;
    if (k == 1) return 1;
    if (k >= cw_w - 1) return 2;
    w_k1 = 2;
    w_k2 = 2;
    w_k  = 0;
    for (int j = cw_w - 2; j >= k; j--) begin
      w_k  = w_k1 + w_k2;
      w_k2 = w_k1;
      w_k1 = w_k;
    end
    return w_k;
  endfunction

  function automatic int nbcac_acc_w(input int cw_w);
    longint unsigned total;
    int w;
    total = 0;
    for (int k = 1; k <= cw_w; k++) total += nbcac_weight(cw_w, k);
    w = 0;
    while ((64'd1 << w) <= total) w++;
    return w;
  endfunction

  function automatic int nbcac_nstep(input int cw_w, input int lanes);
    return (cw_w + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/nbcac_weight_slice.sv
// Combinational partial sum of LANES codeword bits for the current step.
// Weights are a constant table indexed by step*LANES+j; padding positions weigh zero.
module nbcac_weight_slice
  import nbcac_pkg::*;
#(
  parameter int CW_W  = 14,
  parameter int LANES = 1,
  parameter int ACC_W = 11
) (
  input  logic [((nbcac_nstep(CW_W, LANES) > 1) ? $clog2(nbcac_nstep(CW_W, LANES)) : 1)-1:0] step,
  input  logic [LANES-1:0] bits,
  output logic [ACC_W-1:0] psum
);

  localparam int NSTEP  = nbcac_nstep(CW_W, LANES);
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int NPOS   = NSTEP * LANES;

  logic [ACC_W-1:0] wtab [NPOS];

  for (genvar p = 0; p < NPOS; p++) begin : g_wtab
    assign wtab[p] = ACC_W'(nbcac_weight(CW_W, p + 1));
  end

  always_comb begin
    // NOTE: psum gets a default before any conditional add, so no latch is inferred.
    psum = '0;
    for (int s = 0; s < NSTEP; s++) begin
      if (step == STEP_W'(s)) begin
        for (int j = 0; j < LANES; j++) begin
          if (bits[j]) psum = psum + wtab[s*LANES + j];
        end
      end
    end
  end

endmodule

// File: rtl/nbcac_seq_decoder.sv
// Sequential NBCAC decoder: folds LANES codeword bits per cycle into a weighted sum
// and hands out the low DATA_W bits plus an overflow flag over valid/ready.
module nbcac_seq_decoder
  import nbcac_pkg::*;
#(
  parameter int CW_W   = 14,
  parameter int DATA_W = 10,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_v,
  output logic              out_err,
  output logic              busy
);

  localparam int NSTEP  = nbcac_nstep(CW_W, LANES);
  localparam int ACC_W  = nbcac_acc_w(CW_W);
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int SR_W   = NSTEP * LANES;
  localparam int EXT_W  = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;

  logic [1:0]        state;
  logic [SR_W-1:0]   sr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  psum;
  logic [STEP_W-1:0] step;
  logic [EXT_W-1:0]  sum_ext;
  logic              last_step;
  logic              accept;

  nbcac_weight_slice #(
    .CW_W  (CW_W),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_slice (
    .step (step),
    .bits (sr[LANES-1:0]),
    .psum (psum)
  );

  // Extended so the overflow test sees bits above DATA_W even when ACC_W <= DATA_W.
  assign sum_ext   = EXT_W'(acc) + EXT_W'(psum);
  assign last_step = (step == STEP_W'(NSTEP - 1));
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // NOTE: every state register uses <= so all branches read pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sr is an ordinary register, not a memory, so it is cleared with the rest.
      state   <= ST_IDLE;
      sr      <= '0;
      acc     <= '0;
      step    <= '0;
      out_v   <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr    <= SR_W'(in_cw);
            acc   <= '0;
            step  <= '0;
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc  <= sum_ext[ACC_W-1:0];
          sr   <= sr >> LANES;
          step <= step + 1'b1;
          if (last_step) begin
            out_v   <= sum_ext[DATA_W-1:0];
            out_err <= |(sum_ext >> DATA_W);
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Retiring and reloading share one edge so a non-stalling sink sees full rate.
          if (out_ready) begin
            if (in_valid) begin
              sr    <= SR_W'(in_cw);
              acc   <= '0;
              step  <= '0;
              state <= ST_ACC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbcac_seq_decoder.sv
// Scoreboard bench: several decoder configurations run side by side, each checked
// against a Fibonacci-number reference model for value, error flag and latency.
module tb_nbcac_seq_decoder;

  localparam int NCFG = 7;
  localparam int CFG_CW [NCFG] = '{14, 14, 8, 16, 14, 16, 8};
  localparam int CFG_DW [NCFG] = '{10, 10, 6, 11, 10, 11, 6};
  localparam int CFG_L  [NCFG] = '{ 1,  4, 2,  3,  7,  7, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic longint unsigned fib(input int n);
    longint unsigned a, b, t;
    a = 1;
    b = 1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Wire 1 weighs 1; wire k>=2 weighs twice the (cw_w-k+1)-th Fibonacci number.
  function automatic longint unsigned ref_sum(input int cw_w, input longint unsigned cw);
    longint unsigned s;
    s = cw & 64'd1;
    for (int k = 2; k <= cw_w; k++)
      if (((cw >> (k - 1)) & 64'd1) != 0) s += 2 * fib(cw_w - k + 1);
    return s;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int CW    = CFG_CW[g];
    localparam int DW    = CFG_DW[g];
    localparam int L     = CFG_L[g];
    localparam int NSTEP = (CW + L - 1) / L;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_cw;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_v;
    logic          out_err;
    logic          busy;

    longint unsigned exp_q[$];
    int              acc_q[$];
    bit              fresh = 1'b1;

    nbcac_seq_decoder #(
      .CW_W   (CW),
      .DATA_W (DW),
      .LANES  (L)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cw     (in_cw),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_v     (out_v),
      .out_err   (out_err),
      .busy      (busy)
    );

    always @(negedge clk) begin : monitor
      longint unsigned s;
      if (!rst && out_valid) begin
        if (fresh) begin
          fresh = 1'b0;
          if (acc_q.size() == 0) fail($sformatf("cfg%0d latency", g), "result with no accepted codeword");
          else check($sformatf("cfg%0d latency", g), longint'(cyc - acc_q.pop_front()), NSTEP);
        end
        if (exp_q.size() == 0) begin
          fail($sformatf("cfg%0d out_v", g), "unexpected result");
        end else begin
          s = exp_q[0];
          check($sformatf("cfg%0d out_v", g), longint'(out_v), s % (64'd1 << DW));
          check($sformatf("cfg%0d out_err", g), longint'(out_err), longint'((s >> DW) != 0));
          if (out_ready) begin
            void'(exp_q.pop_front());
            fresh = 1'b1;
          end
        end
      end
    end

    // Called at posedge+1; returns whether a codeword was accepted at the next edge.
    task automatic tick(output bit hs);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        exp_q.push_back(ref_sum(CW, longint'(in_cw)));
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        in_cw    = CW'($urandom);
      end
    endtask

    task automatic send(input longint unsigned v);
      bit hs;
      hs       = 1'b0;
      in_cw    = CW'(v);
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !hs; i++) tick(hs);
      if (!hs) begin
        fail($sformatf("cfg%0d accept", g), "codeword never accepted");
        in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      bit hs;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(hs);
      if (exp_q.size() != 0) fail($sformatf("cfg%0d drain", g), "results never delivered");
    endtask

    initial begin : driver
      longint unsigned vecs [7];
      bit hs;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cw     = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d reset out_valid", g), longint'(out_valid), 0);
      check($sformatf("cfg%0d reset busy", g), longint'(busy), 0);
      check($sformatf("cfg%0d reset in_ready", g), longint'(in_ready), 1);
      check($sformatf("cfg%0d reset out_v", g), longint'(out_v), 0);
      check($sformatf("cfg%0d reset out_err", g), longint'(out_err), 0);
      @(posedge clk);
      #1;

      // Single wires, adjacent pairs at both ends, all-ones overflow, zero, top wire.
      vecs = '{64'd1, 64'd2, 64'd6, 64'd3 << (CW - 2), (64'd1 << CW) - 1, 64'd0, 64'd1 << (CW - 1)};
      out_ready = 1'b1;
      foreach (vecs[i]) begin
        send(vecs[i]);
        drain();
      end

      // Stall in DONE with a codeword waiting, then release for same-edge retire and accept.
      out_ready = 1'b0;
      send(longint'($urandom));
      in_cw    = CW'($urandom);
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !out_valid; i++) tick(hs);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check($sformatf("cfg%0d stall in_ready", g), longint'(in_ready), 0);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      tick(hs);
      check($sformatf("cfg%0d release accept", g), longint'(hs), 1);
      drain();

      // Reset while accumulating: result discarded, next codeword decodes cleanly.
      send(longint'($urandom) | 64'd1);
      repeat ((NSTEP - 1) / 2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check($sformatf("cfg%0d midrst out_valid", g), longint'(out_valid), 0);
      check($sformatf("cfg%0d midrst busy", g), longint'(busy), 0);
      in_valid = 1'b0;
      exp_q.delete();
      acc_q.delete();
      fresh = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d postrst in_ready", g), longint'(in_ready), 1);
      @(posedge clk);
      #1;
      send(longint'($urandom));
      drain();

      // Random stream with a randomly stalling sink.
      for (int i = 0; i < 400; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          in_cw    = CW'($urandom);
        end
        tick(hs);
      end
      in_valid = 1'b0;
      drain();
      n_done++;
    end
  end

  initial begin : main
    for (int i = 0; i < 60000 && n_done < NCFG; i++) @(posedge clk);
    if (n_done < NCFG) fail("timeout", "not all configurations finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
